// File: rtl/dma_buffer_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dma_buffer_reader_pkg
//  Description : Shared types and constants for the DMA buffer reader slice:
//                transfer state encoding, output queue depth and an address
//                width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package dma_buffer_reader_pkg;

   // Transfer state encoding
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } dma_state_t;

   // Output queue depth: enough to cover the one-cycle buffer read latency
   localparam int c_QUEUE_DEPTH = 2;

   // Address width for a buffer of the given depth (at least one bit)
   function automatic int addr_width(input int entries);
      return (entries > 1) ? $clog2(entries) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/stream_skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : stream_skid_fifo
//  Description : Two-entry FIFO holding words returned by the buffer until the
//                stream consumer accepts them. Push and pop in the same cycle
//                are both honoured; the head is presented combinationally from
//                the storage registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_skid_fifo
   import dma_buffer_reader_pkg::*;
#(
   parameter int WIDTH = 32
)
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_pushData,
   input  logic             i_pop,
   output logic [1:0]       o_occupancy,
   output logic [WIDTH-1:0] o_headData,
   output logic             o_headValid
);

   logic [WIDTH-1:0] r_mem [c_QUEUE_DEPTH];
   logic             r_rdPtr;
   logic             r_wrPtr;
   logic [1:0]       r_count;

   logic             w_doPop;
   logic             w_doPush;

   // A pop frees the slot it reads, so a push into a full queue is legal then
   assign w_doPop  = i_pop && (r_count != 2'd0);
   assign w_doPush = i_push && ((r_count < 2'(c_QUEUE_DEPTH)) || w_doPop);

   // Storage, pointers and occupancy update
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < c_QUEUE_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_rdPtr <= 1'b0;
         r_wrPtr <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (w_doPush) begin
            r_mem[r_wrPtr] <= i_pushData;
            r_wrPtr        <= ~r_wrPtr;
         end
         if (w_doPop) begin
            r_rdPtr <= ~r_rdPtr;
         end
         r_count <= r_count + {1'b0, w_doPush} - {1'b0, w_doPop};
      end
   end

   assign o_occupancy = r_count;
   assign o_headData  = r_mem[r_rdPtr];
   assign o_headValid = (r_count != 2'd0);

endmodule
`default_nettype wire

// File: rtl/dma_buffer_reader.sv
`default_nettype none
// ============================================================================
//  Module      : dma_buffer_reader
//  Description : Streams a contiguous, wrap-around region of the DMA buffer
//                out of read port B onto a valid/ready word stream. Reads are
//                credit-limited so the two-entry output queue never overflows,
//                giving one word per cycle under continuous ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_buffer_reader
   import dma_buffer_reader_pkg::*;
#(
   parameter  int bitwidth    = 32,
   parameter  int nrOfEntries = 512,
   localparam int AW          = addr_width(nrOfEntries)
)
(
   input  logic                clock,
   input  logic                resetN,
   input  logic                start,
   input  logic [AW-1:0]       startAddress,
   input  logic [AW:0]         wordCount,
   output logic [AW-1:0]       ramAddress,
   input  logic [bitwidth-1:0] ramData,
   output logic [bitwidth-1:0] streamData,
   output logic                streamValid,
   input  logic                streamReady,
   output logic                busy,
   output logic                done
);

   localparam logic [AW:0] c_MAX_WORDS = (AW+1)'(nrOfEntries);

   dma_state_t    r_state;
   logic [AW-1:0] r_ramAddress;
   logic [AW:0]   r_remaining;
   logic          r_inFlight;
   logic          r_busy;
   logic          r_done;

   logic [AW:0]   w_clampedCount;
   logic          w_handshake;
   logic [1:0]    w_occupancy;
   logic          w_headValid;
   logic [2:0]    w_credit;
   logic [2:0]    w_creditLimit;
   logic          w_issue;
   logic          w_lastIssue;
   logic          w_lastPop;

   assign w_clampedCount = (wordCount > c_MAX_WORDS) ? c_MAX_WORDS : wordCount;
   assign w_handshake    = w_headValid && streamReady;

   // Words held or on their way must stay below the queue depth; a pop at this
   // edge frees one slot, hence the limit rises by one on a handshake.
   assign w_credit      = {1'b0, w_occupancy} + {2'b00, r_inFlight};
   assign w_creditLimit = 3'(c_QUEUE_DEPTH) + {2'b00, w_handshake};

   assign w_issue     = (r_state == ST_RUN) && (r_remaining != '0) &&
                        (w_credit < w_creditLimit);
   assign w_lastIssue = w_issue && (r_remaining == (AW+1)'(1));

   // In DRAIN no reads remain, so the queue emptying on a pop is the last word
   assign w_lastPop = (r_state == ST_DRAIN) && w_handshake && !r_inFlight &&
                      (w_occupancy == 2'd1);

   // Transfer FSM with read issue, address/count tracking and status flags
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_state      <= ST_IDLE;
         r_ramAddress <= '0;
         r_remaining  <= '0;
         r_inFlight   <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_inFlight <= w_issue;
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_ramAddress <= startAddress;
                  r_remaining  <= w_clampedCount;
                  if (w_clampedCount == '0) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= ST_RUN;
                     r_busy  <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (w_issue) begin
                  r_ramAddress <= r_ramAddress + AW'(1);
                  r_remaining  <= r_remaining - (AW+1)'(1);
               end
               if (w_lastIssue) begin
                  r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (w_lastPop) begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   stream_skid_fifo #(
      .WIDTH       (bitwidth)
   ) u_queue (
      .i_clk       (clock),
      .i_rst_n     (resetN),
      .i_push      (r_inFlight),
      .i_pushData  (ramData),
      .i_pop       (w_handshake),
      .o_occupancy (w_occupancy),
      .o_headData  (streamData),
      .o_headValid (w_headValid)
   );

   assign ramAddress  = r_ramAddress;
   assign streamValid = w_headValid;
   assign busy        = r_busy;
   assign done        = r_done;

endmodule
`default_nettype wire

// File: doc/dma_buffer_reader.md
# dma_buffer_reader

Drains a contiguous, wrap-around region of the DMA block's dual-port buffer onto a valid/ready word stream. It sits directly downstream of the buffer and drives read port B, whose write enable is tied low at the instantiation. It keeps the stream at one word per cycle under continuous `streamReady`. The buffer's one-cycle registered read latency is absorbed behind a two-entry output queue, so backpressure never drops or duplicates a word.

## Interface
- `bitwidth`, 32, word width; must equal the buffer's `bitwidth`.
- `nrOfEntries`, 512, buffer depth; a power of two. AW = $clog2(nrOfEntries).

- `clock`  in  1  single clock; all state changes on the rising edge.
- `resetN`  in  1  asynchronous, active-low reset.
- `start`  in  1  sampled while idle; begins a transfer.
- `startAddress`  in  AW  first buffer address, sampled with `start`.
- `wordCount`  in  AW+1  number of words, sampled with `start`; values above nrOfEntries are clamped to nrOfEntries.
- `ramAddress`  out  AW  registered read address to buffer port B.
- `ramData`  in  bitwidth  buffer port B read data, valid the cycle after the address is sampled.
- `streamData`  out  bitwidth  output word.
- `streamValid`  out  1  `streamData` is valid.
- `streamReady`  in  1  consumer accepts; a handshake is `streamValid && streamReady` at an edge.
- `busy`  out  1  a transfer is in progress.
- `done`  out  1  single-cycle pulse at transfer completion.

## Operation
- **States:**
  - IDLE: `start` accepted, counters loaded.
  - IDLE -> RUN when `wordCount` > 0.
  - IDLE -> DONE when `wordCount` = 0.
  - RUN: issues reads.
  - RUN -> DRAIN when the last read is issued.
  - DRAIN -> DONE on the handshake of the last word.
  - DONE -> IDLE after one cycle.
- **`start` handling:** ignored in RUN, DRAIN and DONE.
- **Read issue:** a read is issued at an edge when all of the following hold:
  - the state is RUN;
  - remaining reads > 0;
  - `queueOccupancy + inFlight - (handshake this edge)` < 2.
- **Effects of an issued read:**
  - `ramAddress` increments modulo nrOfEntries, wrapping from nrOfEntries-1 to 0.
  - The remaining-read count decrements.
  - `inFlight` is set for the next cycle.
- **Capture:** when `inFlight` is set, `ramData` is written into the queue at that cycle's closing edge. Capture and a handshake pop at the same edge are both honoured.
- **Stream output:** `streamData` and `streamValid` are driven from the queue head. Data is held stable while `streamValid && !streamReady`.
- **Ordering:** words leave in address order; the queue never overflows.
- **Busy and done:**
  - `busy` is high in RUN and DRAIN.
  - `done` is high in DONE only.
  - `busy` falls in the same cycle that `done` rises.
- **Reset (`resetN` low, at any time, including mid-transfer):**
  - state to IDLE; queue and counters cleared; `inFlight` = 0;
  - outputs: `ramAddress` = 0, `streamData` = 0, `streamValid` = 0, `busy` = 0, `done` = 0;
  - no `done` is produced for the aborted transfer.

## Timing
- In the cycle after the edge that samples `start` (cycle 0), `ramAddress` equals `startAddress`.
- First read is issued at edge 1.
- `streamValid` first rises in cycle 2.
- With `streamReady` held high, N words occupy cycles 2 .. N+1 back-to-back.
- `done` is in cycle N+2.
- For `wordCount` = 0, `done` is in cycle 0 and `streamValid` never rises.
- A new `start` is accepted from the cycle after `done` (IDLE).

## Structure
- **Shared DMA package:**
  - state enum typedef (IDLE, RUN, DRAIN, DONE);
  - address-width function/localparam;
  - queue depth constant (2).
- **Sub-module `stream_skid_fifo`:**
  - two-entry FIFO with push, pop, occupancy and head outputs;
  - the parent owns the issue/credit logic and the FSM.

## Test plan
- **Straight run:** mem[i] = 0x100+i, `start` with `startAddress`=0, `wordCount`=4, `streamReady`=1.
  - 0x100..0x103 on cycles 2..5, no gaps.
  - `done` in cycle 6; `busy` high in cycles 0..5.
- **Wrap:** nrOfEntries=512, `startAddress`=510, `wordCount`=4.
  - `ramAddress` sequence 510, 511, 0, 1.
  - Stream carries mem[510], mem[511], mem[0], mem[1].
- **Backpressure:** `wordCount`=16 with `streamReady` pattern 1,0,0,1,0,…
  - All 16 words in order; no duplicates or losses.
  - `streamData` stable while stalled.
  - `ramAddress` never advances more than 2 words beyond the last accepted word.
- **Zero and clamp:**
  - `wordCount`=0: `done` in cycle 0, `streamValid` stays 0.
  - `wordCount`=600: exactly 512 words streamed, then `done`.
- **Start while busy:** a second `start` pulse in cycle 3 of a 4-word transfer.
  - Ignored; exactly 4 words, then one `done`.
- **Reset mid-transfer:** `resetN` low after 2 of 8 words accepted.
  - All outputs 0 immediately; no `done`.
  - A subsequent `start` (`startAddress`=0, `wordCount`=2) streams mem[0], mem[1] normally.
